// File: rtl/arb_pkg.sv
// Shared sizing, state encoding and helpers for the 4-source round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/mux_2s.sv
// Generic 4:1 data multiplexer with a 2-bit select.
module mux_2s #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  input  logic [1:0]   i_sel,
  output logic [W-1:0] o_y
);
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0: o_y = i_d0;
      2'd1: o_y = i_d1;
      2'd2: o_y = i_d2;
      2'd3: o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end
endmodule

// File: rtl/rr_pick.sv
// Round-robin winner search: scans from ptr+1 upward with wrap, first set bit wins.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_any
);
  logic [SEL_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = i_ptr + SEL_W'(k);
      if (!w_found && i_req[w_cand]) begin
        o_idx   = w_cand;
        w_found = 1'b1;
      end
    end
    o_any = w_found;
  end
endmodule

// File: rtl/arb_rr4.sv
// Four-source round-robin arbiter with a one-deep registered output and valid/ready handoff.
module arb_rr4
  import arb_pkg::*;
#(
  parameter int width = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [width-1:0]   d0,
  input  logic [width-1:0]   d1,
  input  logic [width-1:0]   d2,
  input  logic [width-1:0]   d3,
  input  logic               o_ready,
  output logic [NUM_REQ-1:0] ack,
  output logic               o_valid,
  output logic [SEL_W-1:0]   sel,
  output logic [width-1:0]   o
);
  arb_state_t         r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_elig;
  logic [SEL_W-1:0]   w_win;
  logic               w_any;
  logic [width-1:0]   w_dsel;

  // A source acked this cycle has already been served; masking it avoids a double grant.
  assign w_elig = req & ~ack;

  rr_pick u_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  mux_2s #(.W(width)) u_mux (
    .i_d0  (d0),
    .i_d1  (d1),
    .i_d2  (d2),
    .i_d3  (d3),
    .i_sel (w_win),
    .o_y   (w_dsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '1;
      o_valid <= 1'b0;
      sel     <= '0;
      o       <= '0;
      ack     <= '0;
    end else begin
      ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= HOLD;
            r_ptr   <= w_win;
            o_valid <= 1'b1;
            sel     <= w_win;
            o       <= w_dsel;
            ack     <= onehot(w_win);
          end
        end
        HOLD: begin
          if (o_ready) begin
            if (w_any) begin
              r_ptr   <= w_win;
              sel     <= w_win;
              o       <= w_dsel;
              ack     <= onehot(w_win);
            end else begin
              r_state <= IDLE;
              o_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arb_rr4.sv
// Directed-vector bench for arb_rr4 with hand-computed expectations.
module tb_arb_rr4;
  import arb_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [NUM_REQ-1:0] req;
  logic [3:0]         d0, d1, d2, d3;
  logic               o_ready;
  logic [NUM_REQ-1:0] ack;
  logic               o_valid;
  logic [SEL_W-1:0]   sel;
  logic [3:0]         o;

  int n_chk = 0;
  int n_bad = 0;

  arb_rr4 #(.width(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .o_ready (o_ready),
    .ack     (ack),
    .o_valid (o_valid),
    .sel     (sel),
    .o       (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [3:0] d, input logic [3:0] a);
    chk({tag, ".valid"}, 32'(o_valid), 32'(v));
    chk({tag, ".sel"},   32'(sel),     32'(s));
    chk({tag, ".o"},     32'(o),       32'(d));
    chk({tag, ".ack"},   32'(ack),     32'(a));
  endtask

  logic [1:0] exp_sel30 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] exp_d30   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] exp_sel32 [3] = '{2'd1, 2'd3, 2'd1};
  logic [3:0] exp_d32   [3] = '{4'b0010, 4'b1000, 4'b0010};

  initial begin
    rst_n = 1'b0; req = '0; o_ready = 1'b0;
    d0 = 4'b0001; d1 = 4'b0010; d2 = 4'b0100; d3 = 4'b1000;
    #12;
    chk_out("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst_n = 1'b1;

    // single request from source 2
    req = 4'b0100; o_ready = 1'b1;
    tick();
    chk_out("single.cap", 1'b1, 2'd2, 4'b0100, 4'b0100);
    req = '0;
    tick();
    chk_out("single.drain", 1'b0, 2'd2, 4'b0100, 4'b0000);

    // async reset while holding
    req = 4'b0001;
    tick();
    chk_out("prereset", 1'b1, 2'd0, 4'b0001, 4'b0001);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk_out("post_rst", 1'b0, 2'd0, 4'b0000, 4'b0000);

    // all four requesting: full rotation from source 0
    req = 4'b1111; o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rot%0d", i), 1'b1, exp_sel30[i], exp_d30[i], exp_d30[i]);
    end
    req = '0;
    tick();
    chk_out("rot.drain", 1'b0, 2'd0, 4'b0001, 4'b0000);

    // sources 1 and 3 alternate
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("alt%0d", i), 1'b1, exp_sel32[i], exp_d32[i], exp_d32[i]);
    end
    req = '0;
    tick();
    chk_out("alt.drain", 1'b0, 2'd1, 4'b0010, 4'b0000);

    // stall: held data must not follow d1 and new req[3] waits
    req = 4'b0010;
    tick();
    chk_out("stall.cap", 1'b1, 2'd1, 4'b0010, 4'b0010);
    o_ready = 1'b0; d1 = 4'b1111; req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("stall%0d", i), 1'b1, 2'd1, 4'b0010, 4'b0000);
    end
    o_ready = 1'b1;
    tick();
    chk_out("stall.rel", 1'b1, 2'd3, 4'b1000, 4'b1000);
    d1 = 4'b0010; req = '0;
    tick();
    chk_out("stall.drain", 1'b0, 2'd3, 4'b1000, 4'b0000);

    // single source held with o_ready toggling 1,0,1
    req = 4'b0001; o_ready = 1'b1;
    tick();
    chk_out("tog.cap0", 1'b1, 2'd0, 4'b0001, 4'b0001);
    o_ready = 1'b0;
    tick();
    chk_out("tog.stall", 1'b1, 2'd0, 4'b0001, 4'b0000);
    o_ready = 1'b1;
    tick();
    chk_out("tog.cap1", 1'b1, 2'd0, 4'b0001, 4'b0001);
    tick();
    chk_out("tog.masked", 1'b0, 2'd0, 4'b0001, 4'b0000);
    tick();
    chk_out("tog.cap2", 1'b1, 2'd0, 4'b0001, 4'b0001);
    req = '0;
    tick();
    chk_out("tog.drain", 1'b0, 2'd0, 4'b0001, 4'b0000);

    // o_ready is ignored while idle
    o_ready = 1'b0;
    tick();
    chk_out("idle.nordy", 1'b0, 2'd0, 4'b0001, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
